// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle: ROM read port, redirect/halt control and decode handshake.
// master = fetch_sequencer side, slave = ROM/branch/decode environment side.
interface fetch_sequencer_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              rom_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [31:0]       rom_data;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              halt;
   logic              inst_valid;
   logic              inst_ready;
   logic [31:0]       inst;
   logic [ADDR_W-1:0] inst_pc;
   logic [ADDR_W-1:0] inst_next_pc;
   logic              misalign_trap;

   modport master (
      output rom_en, rom_addr, inst_valid, inst, inst_pc, inst_next_pc, misalign_trap,
      input  rom_data, redirect_valid, redirect_pc, halt, inst_ready
   );

   modport slave (
      input  rom_en, rom_addr, inst_valid, inst, inst_pc, inst_next_pc, misalign_trap,
      output rom_data, redirect_valid, redirect_pc, halt, inst_ready
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns fetch PC, drives a 1-cycle ROM, buffers words for decode.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_sequencer #(
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int unsigned       BUF_DEPTH = 2
) (
   input logic               clk,
   input logic               rst,
   fetch_sequencer_if.master fs
);
   localparam int unsigned PW = $clog2(BUF_DEPTH);
   localparam int unsigned CW = PW + 1;

`ifdef FETCH_MISALIGN_TRAP_EN
   typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT, S_TRAP} state_t;
`else
   typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;
`endif

   state_t            state_q;
   logic [ADDR_W-1:0] fetch_pc_q;
   logic [ADDR_W-1:0] req_pc_q;
   logic              inflight_q;
   logic [PW-1:0]     rd_ptr_q;
   logic [PW-1:0]     wr_ptr_q;
   logic [CW-1:0]     count_q;
   logic [31:0]       data_q [BUF_DEPTH];
   logic [ADDR_W-1:0] pc_q   [BUF_DEPTH];

   logic              redirect;
   logic              pop;
   logic              push;
   logic              issue;
   logic [CW:0]       occ;

   // Occupancy counts the in-flight word so a full buffer never gets an unplaced response.
   always_comb begin
      redirect = fs.redirect_valid && (state_q != S_BOOT);
      pop      = (count_q != '0) && fs.inst_ready;
      push     = inflight_q && !redirect;
      occ      = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
      issue    = (state_q == S_RUN) && !fs.halt && !fs.redirect_valid &&
                 (occ < (CW+1)'(BUF_DEPTH));
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   logic trap_q;
   logic misaligned;
   assign misaligned       = |fs.redirect_pc[1:0];
   assign fs.misalign_trap = trap_q;
`else
   logic unused_redirect_lsbs;
   assign unused_redirect_lsbs = ^fs.redirect_pc[1:0];
   assign fs.misalign_trap     = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_BOOT;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= RESET_PC;
         inflight_q <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
         trap_q     <= 1'b0;
`endif
         for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
            data_q[i] <= '0;
            pc_q[i]   <= '0;
         end
      end else begin
         inflight_q <= issue;
         if (issue) begin
            req_pc_q   <= fetch_pc_q;
            fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
         end
         if (push) begin
            data_q[wr_ptr_q] <= fs.rom_data;
            pc_q[wr_ptr_q]   <= req_pc_q;
         end

         case (state_q)
            S_BOOT:  state_q <= S_RUN;
            S_RUN:   if (fs.halt && !inflight_q) state_q <= S_HALT;
            S_HALT:  if (!fs.halt) state_q <= S_RUN;
            default: ;
         endcase

         // Redirect overrides: flush buffer, squash the returning word, restart the PC.
         if (redirect) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            fetch_pc_q <= {fs.redirect_pc[ADDR_W-1:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misaligned) begin
               state_q <= S_TRAP;
               trap_q  <= 1'b1;
            end else begin
               trap_q <= 1'b0;
               if (state_q == S_TRAP) state_q <= S_RUN;
            end
`endif
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
         end
      end
   end

   assign fs.rom_en       = issue;
   assign fs.rom_addr     = fetch_pc_q;
   assign fs.inst_valid   = (count_q != '0);
   assign fs.inst         = data_q[rd_ptr_q];
   assign fs.inst_pc      = pc_q[rd_ptr_q];
   assign fs.inst_next_pc = pc_q[rd_ptr_q] + ADDR_W'(4);
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed stream, stall, redirect, wrap, halt and
// misaligned-redirect scenarios against a ROM holding 0x1000 + word index.
module tb_fetch_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_sequencer_if #(.ADDR_W(32)) fs_if ();

   fetch_sequencer #(
      .ADDR_W   (32),
      .RESET_PC (32'h0),
      .BUF_DEPTH(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .fs (fs_if)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return 32'h1000 + {2'b00, a[31:2]};
   endfunction

   // Synchronous 1-cycle-latency ROM.
   initial fs_if.rom_data = '0;
   always @(posedge clk) if (fs_if.rom_en) fs_if.rom_data <= rom_word(fs_if.rom_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_run(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         e.pc   = start + 32'(4 * i);
         e.word = rom_word(e.pc);
         exp_q.push_back(e);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic stream(input int n);
      repeat (n) cyc();
   endtask

   task automatic wait_head(input logic [31:0] pc, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (fs_if.inst_valid) seen = 1'b1;
      end
      if (!seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL head_timeout: no inst_valid within %0d cycles, expected pc 0x%08h", budget, pc);
      end else begin
         check("head_pc", fs_if.inst_pc, pc);
      end
   endtask

   // Issued in a streaming cycle: the head pops this cycle, everything behind it is flushed.
   task automatic redirect_to(input logic [31:0] target, input logic [31:0] run_start, input int run_len);
      fs_if.redirect_valid = 1'b1;
      fs_if.redirect_pc    = target;
      while (exp_q.size() > 1) void'(exp_q.pop_back());
      push_run(run_start, run_len);
      cyc();
      fs_if.redirect_valid = 1'b0;
      @(negedge clk);
      check("valid_after_redirect", {31'b0, fs_if.inst_valid}, 32'd0);
   endtask

   // Monitor: every accepted instruction is matched against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && fs_if.inst_valid && fs_if.inst_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_inst: got pc 0x%08h expected nothing", fs_if.inst_pc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("inst_pc", fs_if.inst_pc, e.pc);
            check("inst", fs_if.inst, e.word);
            check("inst_next_pc", fs_if.inst_next_pc, e.pc + 32'd4);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      fs_if.redirect_valid = 1'b0;
      fs_if.redirect_pc    = '0;
      fs_if.halt           = 1'b0;
      fs_if.inst_ready     = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_inst_valid", {31'b0, fs_if.inst_valid}, 32'd0);
      check("rst_inst", fs_if.inst, 32'd0);
      check("rst_inst_pc", fs_if.inst_pc, 32'd0);
      check("rst_rom_en", {31'b0, fs_if.rom_en}, 32'd0);
      check("rst_rom_addr", fs_if.rom_addr, 32'd0);
      check("rst_trap", {31'b0, fs_if.misalign_trap}, 32'd0);

      // Boot and load-to-use latency.
      push_run(32'h0, 40);
      cyc();
      rst              = 1'b0;
      fs_if.inst_ready = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         cyc();
         @(negedge clk);
         if (k == 1) begin
            check("boot_rom_en", {31'b0, fs_if.rom_en}, 32'd1);
            check("boot_rom_addr", fs_if.rom_addr, 32'd0);
         end
         check("boot_valid", {31'b0, fs_if.inst_valid}, (k == 3) ? 32'd1 : 32'd0);
         if (k == 3) check("boot_first_pc", fs_if.inst_pc, 32'd0);
      end
      stream(6);

      // Decode stall: fetch stops once the buffer is full; head held steady.
      fs_if.inst_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_rom_en", {31'b0, fs_if.rom_en}, 32'd0);
         check("stall_valid", {31'b0, fs_if.inst_valid}, 32'd1);
         check("stall_head_pc", fs_if.inst_pc, exp_q[0].pc);
         cyc();
      end
      fs_if.inst_ready = 1'b1;
      stream(4);

      // Redirect with a read in flight.
      redirect_to(32'h40, 32'h40, 40);
      wait_head(32'h40, 6);
      stream(4);

      // PC wrap-around.
      redirect_to(32'hFFFF_FFF8, 32'hFFFF_FFF8, 40);
      wait_head(32'hFFFF_FFF8, 6);
      stream(6);

      // Halt: in-flight word still delivered, buffer drains, no new fetches.
      fs_if.halt = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("halt_rom_en", {31'b0, fs_if.rom_en}, 32'd0);
         if (k == 9) check("halt_drained", {31'b0, fs_if.inst_valid}, 32'd0);
         cyc();
      end
      fs_if.halt = 1'b0;
      wait_head(exp_q[0].pc, 8);
      stream(6);

`ifdef FETCH_MISALIGN_TRAP_EN
      redirect_to(32'h42, 32'h0, 0);
      for (int k = 0; k < 4; k++) begin
         check("trap_flag", {31'b0, fs_if.misalign_trap}, 32'd1);
         check("trap_rom_en", {31'b0, fs_if.rom_en}, 32'd0);
         check("trap_valid", {31'b0, fs_if.inst_valid}, 32'd0);
         cyc();
         @(negedge clk);
      end
      cyc();
      fs_if.redirect_valid = 1'b1;
      fs_if.redirect_pc    = 32'h80;
      exp_q.delete();
      push_run(32'h80, 40);
      cyc();
      fs_if.redirect_valid = 1'b0;
      @(negedge clk);
      check("trap_cleared", {31'b0, fs_if.misalign_trap}, 32'd0);
      wait_head(32'h80, 6);
`else
      redirect_to(32'h42, 32'h40, 40);
      check("no_trap", {31'b0, fs_if.misalign_trap}, 32'd0);
      wait_head(32'h40, 6);
`endif
      stream(4);

      fs_if.inst_ready = 1'b0;
      stream(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
